// File: rtl/hud_pkg.sv
// Shared types and constants for the lives HUD.
// FSM state encoding, palette and default line width.
package hud_pkg;

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_BLINK,
    ST_OVER
  } hud_state_e;

  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;

  localparam int H_RES_DEFAULT = 640;

endpackage

// File: rtl/hud_square_hit.sv
// Combinational test: does pixel (x,y) fall inside a
// drawn life square on one side of the HUD.
module hud_square_hit
  import hud_pkg::*;
#(
  parameter int MAX_LIVES = 7,
  parameter int LW        = 3,
  parameter int SQ_W      = 5,
  parameter int SQ_PITCH  = 10,
  parameter int MARGIN    = 10,
  parameter int SQ_Y      = 5,
  parameter int H_RES     = H_RES_DEFAULT
) (
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic [LW-1:0] lives,
  input  logic          side,
  input  logic [LW-1:0] blink_idx,
  input  logic          blink_visible,
  output logic          hit
);

  logic [10:0] x11;
  logic [10:0] y11;
  logic        y_in;
  logic [10:0] lo;
  logic [10:0] hi;
  logic        shown;

  assign x11  = {1'b0, x};
  assign y11  = {1'b0, y};
  assign y_in = (y11 >= 11'(SQ_Y)) &&
                (y11 <= 11'(SQ_Y + SQ_W));

  // side 0 grows rightward from the left edge, side 1 leftward
  always_comb begin
    hit   = 1'b0;
    lo    = '0;
    hi    = '0;
    shown = 1'b0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      if (side)
        lo = 11'(H_RES - MARGIN - i * SQ_PITCH - SQ_W);
      else
        lo = 11'(MARGIN + i * SQ_PITCH);
      hi    = lo + 11'(SQ_W);
      shown = (LW'(i) < lives) ||
              (blink_visible && (blink_idx == LW'(i)));
      if (y_in && shown && (x11 >= lo) && (x11 <= hi))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/lives_hud.sv
// Two-player lives counter with blink-on-hit and
// game-over detection, rendered as a registered HUD bar.
module lives_hud
  import hud_pkg::*;
#(
  parameter int MAX_LIVES    = 7,
  parameter int SQ_W         = 5,
  parameter int SQ_PITCH     = 10,
  parameter int MARGIN       = 10,
  parameter int SQ_Y         = 5,
  parameter int BAR_H        = 12,
  parameter int H_RES        = H_RES_DEFAULT,
  parameter int BLINK_FRAMES = 8,
  parameter int BLINK_PHASES = 6,
  localparam int LW = $clog2(MAX_LIVES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          lose_l,
  input  logic          lose_r,
  input  logic          new_game,
  output logic [2:0]    rgb,
  output logic [LW-1:0] lives_l,
  output logic [LW-1:0] lives_r,
  output logic          game_over,
  output logic          winner
);

  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int PW =
    (BLINK_PHASES > 1) ? $clog2(BLINK_PHASES) : 1;

  hud_state_e    state_q, state_d;
  logic [LW-1:0] lives_l_q, lives_l_d;
  logic [LW-1:0] lives_r_q, lives_r_d;
  logic          game_over_q, game_over_d;
  logic          winner_q, winner_d;
  logic          blink_side_q, blink_side_d;
  logic [LW-1:0] blink_idx_q, blink_idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    rgb_q, rgb_d;

  logic          dec_l;
  logic          dec_r;
  logic [LW-1:0] nl;
  logic [LW-1:0] nr;
  logic          blink_on;
  logic          hit_l;
  logic          hit_r;

  assign dec_l = lose_l && (lives_l_q != '0) &&
                 (state_q != ST_OVER);
  assign dec_r = lose_r && (lives_r_q != '0) &&
                 (state_q != ST_OVER);
  assign nl    = lives_l_q - LW'(dec_l);
  assign nr    = lives_r_q - LW'(dec_r);

  always_comb begin
    state_d      = state_q;
    lives_l_d    = lives_l_q;
    lives_r_d    = lives_r_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    blink_side_d = blink_side_q;
    blink_idx_d  = blink_idx_q;
    frame_d      = frame_q;
    phase_d      = phase_q;
    if (new_game) begin
      state_d     = ST_PLAY;
      lives_l_d   = LW'(MAX_LIVES);
      lives_r_d   = LW'(MAX_LIVES);
      game_over_d = 1'b0;
      winner_d    = 1'b0;
      frame_d     = '0;
      phase_d     = '0;
    end else if (dec_l || dec_r) begin
      lives_l_d = nl;
      lives_r_d = nr;
      frame_d   = '0;
      phase_d   = '0;
      if ((nl == '0) || (nr == '0)) begin
        // a double knockout goes to the left player
        state_d     = ST_OVER;
        game_over_d = 1'b1;
        winner_d    = (nl == '0) && (nr != '0);
      end else begin
        state_d      = ST_BLINK;
        blink_side_d = !dec_l;
        blink_idx_d  = dec_l ? nl : nr;
      end
    end else if ((state_q == ST_BLINK) && frame_tick) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        if (phase_q == PW'(BLINK_PHASES - 1)) begin
          phase_d = '0;
          state_d = ST_PLAY;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  assign blink_on = (state_q == ST_BLINK) && !phase_q[0];

  hud_square_hit #(
    .MAX_LIVES(MAX_LIVES), .LW(LW), .SQ_W(SQ_W),
    .SQ_PITCH(SQ_PITCH), .MARGIN(MARGIN),
    .SQ_Y(SQ_Y), .H_RES(H_RES)
  ) u_hit_l (
    .x(x), .y(y), .lives(lives_l_q), .side(1'b0),
    .blink_idx(blink_idx_q),
    .blink_visible(blink_on && !blink_side_q),
    .hit(hit_l)
  );

  hud_square_hit #(
    .MAX_LIVES(MAX_LIVES), .LW(LW), .SQ_W(SQ_W),
    .SQ_PITCH(SQ_PITCH), .MARGIN(MARGIN),
    .SQ_Y(SQ_Y), .H_RES(H_RES)
  ) u_hit_r (
    .x(x), .y(y), .lives(lives_r_q), .side(1'b1),
    .blink_idx(blink_idx_q),
    .blink_visible(blink_on && blink_side_q),
    .hit(hit_r)
  );

  always_comb begin
    rgb_d = BLACK;
    if (hit_l || hit_r)
      rgb_d = BLACK;
    else if ({1'b0, y} < 11'(BAR_H))
      rgb_d = game_over_q ? RED : WHITE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_PLAY;
      lives_l_q    <= LW'(MAX_LIVES);
      lives_r_q    <= LW'(MAX_LIVES);
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      blink_side_q <= 1'b0;
      blink_idx_q  <= '0;
      frame_q      <= '0;
      phase_q      <= '0;
      rgb_q        <= BLACK;
    end else begin
      state_q      <= state_d;
      lives_l_q    <= lives_l_d;
      lives_r_q    <= lives_r_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      blink_side_q <= blink_side_d;
      blink_idx_q  <= blink_idx_d;
      frame_q      <= frame_d;
      phase_q      <= phase_d;
      rgb_q        <= rgb_d;
    end
  end

  assign rgb       = rgb_q;
  assign lives_l   = lives_l_q;
  assign lives_r   = lives_r_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule
